// File: rtl/bram_stream_reader_if.sv
// RAM read port plus output stream bundle for bram_stream_reader.
// The master side is the reader. The slave side is the RAM and stream consumer.
interface bram_stream_reader_if #(
    parameter int RAM_WIDTH = 18,
    parameter int ADDR_W    = 10
);
    logic [ADDR_W-1:0]    ram_addr;
    logic                 ram_en;
    logic                 ram_regce;
    logic [RAM_WIDTH-1:0] ram_dout;
    logic [RAM_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;

    modport master (
        output ram_addr, ram_en, ram_regce, m_data, m_valid, m_last,
        input  ram_dout, m_ready
    );

    modport slave (
        input  ram_addr, ram_en, ram_regce, m_data, m_valid, m_last,
        output ram_dout, m_ready
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Burst reader for a BRAM with a 2-cycle output-registered read port.
// Issued reads are credit-limited against a small output FIFO, so the FIFO never overflows.
module bram_stream_reader #(
    parameter int RAM_WIDTH  = 18,
    parameter int RAM_DEPTH  = 1024,
    parameter int FIFO_DEPTH = 4,
    localparam int ADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic              clka,
    input  logic              rstb,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    bram_stream_reader_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state, state_next;
    logic [RAM_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [1:0]           vpipe;
    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W:0]      len_q, issued, popped;
    logic                 done_q, done_next;
    logic                 issue, push, pop, valid, last;
    logic [OCC_W-1:0]     occupancy;

    assign valid      = (count != '0);
    assign last       = valid && (popped == len_q - (ADDR_W+1)'(1));
    assign push       = vpipe[1];
    assign pop        = valid & bus.m_ready;
    // Words already owed to the FIFO plus those still in it after this cycle's pop.
    assign occupancy  = OCC_W'(count) + OCC_W'(vpipe[0]) + OCC_W'(vpipe[1]) - OCC_W'(pop);

    assign bus.m_valid   = valid;
    assign bus.m_data    = valid ? mem[rd_ptr] : '0;
    assign bus.m_last    = last;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_en    = issue;
    assign bus.ram_regce = 1'b1;
    assign busy          = (state != IDLE);
    assign done          = done_q;

    always_ff @(posedge clka) begin
        if (rstb) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) state_next = RUN;
                    else              done_next  = 1'b1;
                end
            end
            RUN: begin
                if (occupancy < OCC_W'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if ((issued + (ADDR_W+1)'(1)) == len_q) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (vpipe == 2'b00 && pop && last && count == CNT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            vpipe  <= '0;
            addr_q <= '0;
            len_q  <= '0;
            issued <= '0;
            popped <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            vpipe <= {vpipe[0], issue};
            if (state == IDLE && start && length != '0) begin
                addr_q <= base_addr;
                len_q  <= length;
                issued <= '0;
                popped <= '0;
            end
            if (issue) begin
                addr_q <= (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                issued <= issued + (ADDR_W+1)'(1);
            end
            if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
                popped <= popped + (ADDR_W+1)'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clka) begin
        if (push) mem[wr_ptr] <= bus.ram_dout;
    end
endmodule
